sp_ram_arbiter: RTL and testbench

//   Shares one sp_ram instance between two requesters (m0, m1) using a req/gnt/rvalid protocol.

---
 rtl/sp_ram_arbiter.sv | 131 +++++++++++++
 tb/tb_sp_ram_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arbiter.sv
// rtl/sp_ram_arbiter.sv - two-master round-robin arbiter in front of one single-port RAM
//
// Purpose
//   Shares a single-port RAM between masters m0 and m1 with a req/gnt/rvalid
//   handshake. Grants are combinational and alternate under contention. One
//   access per cycle is sustained. The read response returns a fixed number of
//   cycles after the grant and is steered to the master that won the access.
//
// Configuration
//   SP_RAM_ARB_OUTREG_EN  when defined, registers rvalid/id/rdata a second time
//                         (gnt-to-rvalid = 2 cycles); otherwise 1 cycle.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   mX_req_i            X in {0,1}: request, held until mX_gnt_o
//   mX_addr_i/we_i/be_i/wdata_i   access attributes, stable until granted
//   mX_gnt_o            access accepted this cycle (combinational)
//   mX_rvalid_o         response for an earlier granted access (reads and writes)
//   mX_rdata_o          read data, meaningful only for read responses
//   ram_en_o/addr_o/we_o/be_o/wdata_o   to the RAM macro
//   ram_rdata_i         from the RAM macro, registered one cycle after en
module sp_ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m0_req_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_gnt_o,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    input  logic                    m1_req_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_gnt_o,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    // Index of the most recently granted master; reset to 1 so m0 wins first.
    logic last_q;
    logic gnt0;
    logic gnt1;
    logic any_gnt;

    // First response stage: valid and owner of the access issued last cycle.
    logic rsp_v_q;
    logic rsp_id_q;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        // Reset blocks grants so nothing reaches the RAM in a reset cycle.
        if (!rst) begin
            if (m0_req_i && m1_req_i) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = m0_req_i;
                gnt1 = m1_req_i;
            end
        end
    end

    assign any_gnt  = gnt0 | gnt1;
    assign m0_gnt_o = gnt0;
    assign m1_gnt_o = gnt1;

    // Attributes follow m0 unless m1 is granted; en=0 keeps idle cycles harmless.
    assign ram_en_o    = any_gnt;
    assign ram_addr_o  = gnt1 ? m1_addr_i  : m0_addr_i;
    assign ram_we_o    = gnt1 ? m1_we_i    : m0_we_i;
    assign ram_be_o    = gnt1 ? m1_be_i    : m0_be_i;
    assign ram_wdata_o = gnt1 ? m1_wdata_i : m0_wdata_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q   <= 1'b1;
            rsp_v_q  <= 1'b0;
            rsp_id_q <= 1'b0;
        end else begin
            if (any_gnt) begin
                last_q <= gnt1;
            end
            rsp_v_q  <= any_gnt;
            rsp_id_q <= gnt1;
        end
    end

`ifdef SP_RAM_ARB_OUTREG_EN
    // Second stage retimes the response; RAM data is captured alongside.
    logic                  rsp2_v_q;
    logic                  rsp2_id_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp2_v_q  <= 1'b0;
            rsp2_id_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rsp2_v_q  <= rsp_v_q;
            rsp2_id_q <= rsp_id_q;
            rdata_q   <= ram_rdata_i;
        end
    end

    assign m0_rvalid_o = rsp2_v_q & !rsp2_id_q;
    assign m1_rvalid_o = rsp2_v_q &  rsp2_id_q;
    assign m0_rdata_o  = rdata_q;
    assign m1_rdata_o  = rdata_q;
`else
    assign m0_rvalid_o = rsp_v_q & !rsp_id_q;
    assign m1_rvalid_o = rsp_v_q &  rsp_id_q;
    assign m0_rdata_o  = ram_rdata_i;
    assign m1_rdata_o  = ram_rdata_i;
`endif

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb/tb_sp_ram_arbiter.sv - directed self-checking bench for sp_ram_arbiter
module tb_sp_ram_arbiter;

`ifdef SP_RAM_ARB_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [7:0]  m0_addr, m1_addr;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_en, ram_we;
    logic [7:0]  ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected response pipeline, fed only by the bench's expected grants.
    logic pv [2];
    logic pid[2];

    logic [31:0] mem[64];

    always #5 clk = ~clk;

    sp_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be),
        .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
        .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    // Behavioural single-port RAM: registered read returning the pre-write word.
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= mem[ram_addr[7:2]];
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be[b]) mem[ram_addr[7:2]][8*b +: 8] = ram_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [7:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
        m0_req = req; m0_we = we; m0_addr = a; m0_be = be; m0_wdata = wd;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [7:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
        m1_req = req; m1_we = we; m1_addr = a; m1_be = be; m1_wdata = wd;
    endtask

    // One clock: check grants and RAM drive before the edge, responses after it.
    task automatic step(input string tag, input logic e0, input logic e1);
        logic was_rst;
        #1;
        chk({tag, ".gnt0"}, 32'(m0_gnt), 32'(e0));
        chk({tag, ".gnt1"}, 32'(m1_gnt), 32'(e1));
        chk({tag, ".ram_en"}, 32'(ram_en), 32'(e0 | e1));
        if (e0 | e1) chk({tag, ".ram_addr"}, 32'(ram_addr), 32'(e1 ? m1_addr : m0_addr));
        was_rst = rst;
        @(posedge clk);
        #1;
        pv[1] = pv[0]; pid[1] = pid[0];
        pv[0] = e0 | e1; pid[0] = e1;
        if (was_rst) begin
            pv[0] = 1'b0; pv[1] = 1'b0;
        end
        chk({tag, ".m0_rvalid"}, 32'(m0_rvalid), 32'(pv[LAT-1] & !pid[LAT-1]));
        chk({tag, ".m1_rvalid"}, 32'(m1_rvalid), 32'(pv[LAT-1] &  pid[LAT-1]));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < LAT - 1; i++) step(tag, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        pv[0] = 1'b0; pv[1] = 1'b0; pid[0] = 1'b0; pid[1] = 1'b0;
        rst = 1'b1;
        set_m0(1'b1, 1'b0, 8'h00, 4'hF, 32'h0);
        set_m1(1'b1, 1'b0, 8'h04, 4'hF, 32'h0);

        // Reset with both masters requesting: nothing is granted or returned.
        for (int i = 0; i < 3; i++) step("reset", 1'b0, 1'b0);

        // Continuous contention straight after reset alternates starting at m0.
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step("contend", (i % 2) == 0, (i % 2) == 1);
        set_m0(1'b0, 1'b0, 8'h00, 4'hF, 32'h0);
        set_m1(1'b0, 1'b0, 8'h04, 4'hF, 32'h0);
        step("contend_tail", 1'b0, 1'b0);
        drain("contend_drain");

        // Solo write then read by m1.
        set_m1(1'b1, 1'b1, 8'h10, 4'hF, 32'hDEADBEEF);
        step("m1_write", 1'b0, 1'b1);
        set_m1(1'b1, 1'b0, 8'h10, 4'hF, 32'h0);
        step("m1_read", 1'b0, 1'b1);
        set_m1(1'b0, 1'b0, 8'h10, 4'hF, 32'h0);
        drain("m1_read_drain");
        chk("m1_rdata", m1_rdata, 32'hDEADBEEF);
        step("solo_idle", 1'b0, 1'b0);

        // Partial byte-enable write merges into the existing word.
        set_m0(1'b1, 1'b1, 8'h20, 4'hF, 32'h11223344);
        step("m0_write_full", 1'b1, 1'b0);
        set_m0(1'b1, 1'b1, 8'h20, 4'b0101, 32'hAABBCCDD);
        step("m0_write_be", 1'b1, 1'b0);
        set_m0(1'b1, 1'b0, 8'h20, 4'hF, 32'h0);
        step("m0_read_be", 1'b1, 1'b0);
        set_m0(1'b0, 1'b0, 8'h20, 4'hF, 32'h0);
        drain("be_drain");
        chk("m0_rdata_be", m0_rdata, 32'h11BB33DD);

        // Reset right after an m0 read grant drops the response; last grant was
        // m0, so only the reset can make m0 win the next contention.
        set_m0(1'b1, 1'b0, 8'h10, 4'hF, 32'h0);
        step("pre_rst_read", 1'b1, 1'b0);
        rst = 1'b1;
        step("mid_rst", 1'b0, 1'b0);
        rst = 1'b0;
        set_m0(1'b0, 1'b0, 8'h10, 4'hF, 32'h0);
        step("post_rst_idle0", 1'b0, 1'b0);
        step("post_rst_idle1", 1'b0, 1'b0);
        set_m0(1'b1, 1'b0, 8'h00, 4'hF, 32'h0);
        set_m1(1'b1, 1'b0, 8'h04, 4'hF, 32'h0);
        step("post_rst_c0", 1'b1, 1'b0);
        step("post_rst_c1", 1'b0, 1'b1);
        set_m0(1'b0, 1'b0, 8'h00, 4'hF, 32'h0);
        set_m1(1'b0, 1'b0, 8'h04, 4'hF, 32'h0);
        step("post_rst_tail", 1'b0, 1'b0);
        drain("post_rst_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
